// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between issue logic and alu_sequencer.
// master = issuer side, slave = sequencer side.
interface alu_sequencer_if #(
   parameter int WIDTH = 64
);
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_data;
   logic [3:0]       resp_flags;

   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_flags
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_data, resp_flags
   );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle initiator for the LEGv8 ALU: maps opcodes to FS/C0 and
// builds MUL from 64 sequenced ALU ADD cycles (shift-and-add).
module alu_sequencer #(
   parameter int WIDTH = 64
) (
   input  logic             clock,
   input  logic             reset,
   alu_sequencer_if.slave   bus,
   output logic [WIDTH-1:0] alu_A,
   output logic [WIDTH-1:0] alu_B,
   output logic [4:0]       alu_FS,
   output logic             alu_C0,
   input  logic [WIDTH-1:0] alu_F,
   input  logic [3:0]       alu_status
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_MUL  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_ORR = 3'b011;
   localparam logic [2:0] OP_EOR = 3'b100;
   localparam logic [2:0] OP_LSL = 3'b101;
   localparam logic [2:0] OP_LSR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   localparam int CW = $clog2(WIDTH);

   logic [1:0]       state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    count_q, count_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [3:0]       flags_q, flags_d;

   logic [5:0]       fs_c0;
   logic [WIDTH-1:0] acc_nxt;

   always_comb begin
      fs_c0 = 6'b000000;
      case (op_q)
         OP_ADD:  fs_c0 = {5'b01000, 1'b0};
         OP_SUB:  fs_c0 = {5'b01010, 1'b1};
         OP_AND:  fs_c0 = {5'b00000, 1'b0};
         OP_ORR:  fs_c0 = {5'b00100, 1'b0};
         OP_EOR:  fs_c0 = {5'b01100, 1'b0};
         OP_LSL:  fs_c0 = {5'b10000, 1'b0};
         OP_LSR:  fs_c0 = {5'b10100, 1'b0};
         default: fs_c0 = 6'b000000;
      endcase
   end

   // ALU drive depends only on registered state, keeping alu_F out of this path
   always_comb begin
      alu_A  = '0;
      alu_B  = '0;
      alu_FS = 5'b00000;
      alu_C0 = 1'b0;
      if (state_q == S_EXEC) begin
         alu_A            = a_q;
         alu_B            = b_q;
         {alu_FS, alu_C0} = fs_c0;
      end else if (state_q == S_MUL) begin
         alu_A  = acc_q;
         alu_B  = a_q;
         alu_FS = 5'b01000;
      end
   end

   assign acc_nxt = b_q[0] ? alu_F : acc_q;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      count_d = count_q;
      valid_d = valid_q;
      data_d  = data_q;
      flags_d = flags_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               op_d    = bus.req_op;
               a_d     = bus.req_a;
               b_d     = bus.req_b;
               acc_d   = '0;
               count_d = '0;
               state_d = (bus.req_op == OP_MUL) ? S_MUL : S_EXEC;
            end
         end
         S_EXEC: begin
            data_d = alu_F;
            if (op_q == OP_ADD || op_q == OP_SUB)
               flags_d = alu_status;
            else
               flags_d = {2'b00, alu_status[1:0]};
            valid_d = 1'b1;
            state_d = S_DONE;
         end
         S_MUL: begin
            acc_d   = acc_nxt;
            a_d     = a_q << 1;
            b_d     = b_q >> 1;
            count_d = count_q + 1'b1;
            if (count_q == CW'(WIDTH - 1)) begin
               data_d  = acc_nxt;
               flags_d = {2'b00, acc_nxt[WIDTH-1], acc_nxt == '0};
               valid_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.resp_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         flags_q <= flags_d;
      end
   end

   assign bus.req_ready  = (state_q == S_IDLE);
   assign bus.resp_valid = valid_q;
   assign bus.resp_data  = data_q;
   assign bus.resp_flags = flags_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU plus an
// arithmetic reference model for results, flags and latency.
module tb_alu_sequencer;
   logic        clock;
   logic        reset;
   logic [63:0] alu_A, alu_B, alu_F;
   logic [4:0]  alu_FS;
   logic        alu_C0;
   logic [3:0]  alu_status;

   int n_tests = 0;
   int n_fail  = 0;

   alu_sequencer_if #(.WIDTH(64)) bus ();

   alu_sequencer #(.WIDTH(64)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .alu_A      (alu_A),
      .alu_B      (alu_B),
      .alu_FS     (alu_FS),
      .alu_C0     (alu_C0),
      .alu_F      (alu_F),
      .alu_status (alu_status)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // External combinational ALU
   logic [63:0] ax, bx;
   logic [64:0] sum;
   logic        cf, vf;
   always_comb begin
      ax    = alu_FS[0] ? ~alu_A : alu_A;
      bx    = alu_FS[1] ? ~alu_B : alu_B;
      sum   = {1'b0, ax} + {1'b0, bx} + {64'b0, alu_C0};
      alu_F = '0;
      cf    = 1'b0;
      vf    = 1'b0;
      case (alu_FS[4:2])
         3'b000: alu_F = ax & bx;
         3'b001: alu_F = ax | bx;
         3'b010: begin
            alu_F = sum[63:0];
            cf    = sum[64];
            vf    = (ax[63] == bx[63]) && (sum[63] != ax[63]);
         end
         3'b011: alu_F = ax ^ bx;
         3'b100: alu_F = ax << bx[5:0];
         3'b101: alu_F = ax >> bx[5:0];
         default: alu_F = '0;
      endcase
      alu_status = {vf, cf, alu_F[63], alu_F == 64'd0};
   end

   function automatic void ref_op(input logic [2:0] op, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] r,
                                  output logic [3:0] f);
      logic [64:0] wide;
      logic c, v;
      c = 1'b0;
      v = 1'b0;
      case (op)
         3'd0: begin
            wide = {1'b0, a} + {1'b0, b};
            r = wide[63:0];
            c = wide[64];
            v = (a[63] == b[63]) && (r[63] != a[63]);
         end
         3'd1: begin
            r = a - b;
            c = (a >= b);
            v = (a[63] != b[63]) && (r[63] != a[63]);
         end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = a << b[5:0];
         3'd6: r = a >> b[5:0];
         default: r = a * b;
      endcase
      f = {v, c, r[63], r == 64'd0};
   endfunction

   function automatic logic [5:0] ref_fs(input logic [2:0] op);
      case (op)
         3'd0: return 6'b010000;
         3'd1: return 6'b010101;
         3'd2: return 6'b000000;
         3'd3: return 6'b001000;
         3'd4: return 6'b011000;
         3'd5: return 6'b100000;
         3'd6: return 6'b101000;
         default: return 6'b000000;
      endcase
   endfunction

   task automatic do_op(input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] d,
                        output logic [3:0] f, output int lat,
                        output logic [5:0] fsc);
      logic rdy;
      bit acc;
      d = '0; f = '0; fsc = '0; lat = -1; acc = 0;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op = op;
      bus.req_a = a;
      bus.req_b = b;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         rdy = bus.req_ready;
         @(posedge clock);
         if (rdy) begin acc = 1; break; end
      end
      #1 bus.req_valid = 1'b0;
      if (!acc) return;
      lat = 1;
      forever begin
         @(negedge clock);
         if (lat == 1) fsc = {alu_FS, alu_C0};
         if (bus.resp_valid) break;
         if (lat > 200) begin lat = -1; return; end
         @(posedge clock);
         lat++;
      end
      d = bus.resp_data;
      f = bus.resp_flags;
      bus.resp_ready = 1'b1;
      @(posedge clock);
      #1 bus.resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      n_tests++;
      if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_hs: got %b want 10", {bus.req_ready, bus.resp_valid});
      end
      n_tests++;
      if ({bus.resp_data, bus.resp_flags} !== 68'd0) begin
         n_fail++;
         $display("FAIL reset_resp: got %h/%b want 0", bus.resp_data, bus.resp_flags);
      end
      n_tests++;
      if ({alu_A, alu_B, alu_FS, alu_C0} !== 134'd0) begin
         n_fail++;
         $display("FAIL reset_alu: got %h %h %b %b want 0", alu_A, alu_B, alu_FS, alu_C0);
      end
   endtask

   task automatic test_directed();
      logic [2:0]  ops[10]   = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd5, 3'd6, 3'd4, 3'd7, 3'd7, 3'd7};
      logic [63:0] as[10]    = '{64'd5, 64'h7FFF_FFFF_FFFF_FFFF, 64'd5, 64'd3, 64'd1,
                                 64'hF0, 64'hFF, 64'hFFFF_FFFF, 64'd12345,
                                 64'h8000_0000_0000_0000};
      logic [63:0] bs[10]    = '{64'd7, 64'd1, 64'd5, 64'd5, 64'd63, 64'h44, 64'hFF,
                                 64'hFFFF_FFFF, 64'd0, 64'd2};
      logic [63:0] exp_d[10] = '{64'd12, 64'h8000_0000_0000_0000, 64'd0,
                                 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000,
                                 64'h0F, 64'd0, 64'hFFFF_FFFE_0000_0001, 64'd0, 64'd0};
      logic [3:0]  exp_f[10] = '{4'b0000, 4'b1010, 4'b0101, 4'b0010, 4'b0010,
                                 4'b0000, 4'b0001, 4'b0010, 4'b0001, 4'b0001};
      logic [63:0] d;
      logic [3:0]  f;
      logic [5:0]  fsc;
      int lat, exp_lat;
      for (int i = 0; i < 10; i++) begin
         do_op(ops[i], as[i], bs[i], d, f, lat, fsc);
         exp_lat = (ops[i] == 3'd7) ? 65 : 2;
         n_tests++;
         if (d !== exp_d[i] || f !== exp_f[i]) begin
            n_fail++;
            $display("FAIL dir_result[%0d]: got %h/%b want %h/%b", i, d, f, exp_d[i], exp_f[i]);
         end
         n_tests++;
         if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, exp_lat);
         end
      end
   endtask

   task automatic test_fs_map();
      logic [63:0] d;
      logic [3:0]  f;
      logic [5:0]  fsc;
      int lat;
      for (int op = 0; op < 7; op++) begin
         do_op(3'(op), {$urandom, $urandom}, {$urandom, $urandom}, d, f, lat, fsc);
         n_tests++;
         if (fsc !== ref_fs(3'(op))) begin
            n_fail++;
            $display("FAIL fs_map[%0d]: got %b want %b", op, fsc, ref_fs(3'(op)));
         end
      end
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [63:0] a, b, d, ed;
      logic [3:0]  f, ef;
      logic [5:0]  fsc;
      int lat, exp_lat;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 3)) << 62;
         if ($urandom_range(0, 3) == 0) b = a;
         ref_op(op, a, b, ed, ef);
         do_op(op, a, b, d, f, lat, fsc);
         exp_lat = (op == 3'd7) ? 65 : 2;
         n_tests++;
         if (d !== ed || f !== ef || lat != exp_lat) begin
            n_fail++;
            $display("FAIL rand[%0d] op=%0d: got %h/%b lat %0d want %h/%b lat %0d",
                     i, op, d, f, lat, ed, ef, exp_lat);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] d;
      logic [3:0]  f;
      bit seen;
      seen = 0;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op = 3'd0;
      bus.req_a = 64'd40;
      bus.req_b = 64'd2;
      @(posedge clock);
      #1;
      bus.req_op = 3'd1;
      bus.req_a = 64'd100;
      bus.req_b = 64'd1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (bus.resp_valid) begin seen = 1; break; end
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL bp_valid: got 0 want 1");
      end
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clock);
         n_tests++;
         if ({bus.resp_valid, bus.req_ready} !== 2'b10 ||
             bus.resp_data !== 64'd42 || bus.resp_flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got v%b r%b %h/%b want v1 r0 %h/%b", i,
                     bus.resp_valid, bus.req_ready, bus.resp_data, bus.resp_flags,
                     64'd42, 4'b0000);
         end
         @(posedge clock);
      end
      #1 bus.resp_ready = 1'b1;
      @(posedge clock);
      #1 bus.resp_ready = 1'b0;
      @(negedge clock);
      n_tests++;
      if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL bp_release: got r%b v%b want r1 v0", bus.req_ready, bus.resp_valid);
      end
      @(posedge clock);
      #1 bus.req_valid = 1'b0;
      @(negedge clock);
      n_tests++;
      if (bus.req_ready !== 1'b0 || {alu_FS, alu_C0} !== 6'b010101) begin
         n_fail++;
         $display("FAIL bp_next_accept: got r%b fs%b want r0 fs010101",
                  bus.req_ready, {alu_FS, alu_C0});
      end
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (bus.resp_valid) begin seen = 1; break; end
      end
      d = bus.resp_data;
      f = bus.resp_flags;
      n_tests++;
      if (!seen || d !== 64'd99 || f !== 4'b0100) begin
         n_fail++;
         $display("FAIL bp_next_result: got v%b %h/%b want v1 %h/%b", seen, d, f,
                  64'd99, 4'b0100);
      end
      bus.resp_ready = 1'b1;
      @(posedge clock);
      #1 bus.resp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_mul();
      logic [63:0] d;
      logic [3:0]  f;
      logic [5:0]  fsc;
      int lat;
      bit leaked;
      leaked = 0;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op = 3'd7;
      bus.req_a = {$urandom, $urandom};
      bus.req_b = {$urandom, $urandom} | 64'd1;
      @(posedge clock);
      #1 bus.req_valid = 1'b0;
      repeat (29) @(posedge clock);
      @(negedge clock);
      n_tests++;
      if (alu_FS !== 5'b01000 || bus.req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mul_iter30: got fs%b r%b want fs01000 r0", alu_FS, bus.req_ready);
      end
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      n_tests++;
      if ({bus.req_ready, bus.resp_valid} !== 2'b10 ||
          {alu_A, alu_B, alu_FS, alu_C0} !== 134'd0) begin
         n_fail++;
         $display("FAIL mul_reset: got r%b v%b A%h B%h fs%b c%b want r1 v0 zeros",
                  bus.req_ready, bus.resp_valid, alu_A, alu_B, alu_FS, alu_C0);
      end
      for (int i = 0; i < 70; i++) begin
         @(negedge clock);
         if (bus.resp_valid) leaked = 1;
      end
      n_tests++;
      if (leaked) begin
         n_fail++;
         $display("FAIL mul_no_resp: got 1 want 0");
      end
      do_op(3'd0, 64'd1, 64'd1, d, f, lat, fsc);
      n_tests++;
      if (d !== 64'd2 || f !== 4'b0000 || lat != 2) begin
         n_fail++;
         $display("FAIL post_reset_add: got %h/%b lat %0d want 2/0000 lat 2", d, f, lat);
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.resp_ready = 1'b0;
      test_reset();
      test_directed();
      test_fs_map();
      test_random();
      test_backpressure();
      test_reset_mid_mul();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle initiator for the 64-bit LEGv8 ALU datapath. It accepts operation requests over a valid/ready handshake, translates each opcode into the ALU function-select word (FS) and carry-in (C0), drives the ALU operands, captures the result and status, and returns them over a second valid/ready handshake. MUL has no native ALU function, so it is built from 64 sequenced ALU ADD cycles (shift-and-add). The block sits between the issue/control logic and the combinational ALU.

## Interface

- WIDTH, 64, datapath width; must equal ALU width.

- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 LSL, 110 LSR, 111 MUL.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B; shift amount is req_b[5:0].
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_data  out  WIDTH  result.
- resp_flags  out  4  {V, C, N, Z}.
- alu_A  out  WIDTH  ALU operand A.
- alu_B  out  WIDTH  ALU operand B.
- alu_FS  out  5  ALU function select: FS[0] invert A, FS[1] invert B, FS[4:2] select (000 AND, 001 OR, 010 ADD, 011 XOR, 100 LSL, 101 LSR).
- alu_C0  out  1  ALU carry-in.
- alu_F  in  WIDTH  ALU result (combinational from alu_A/alu_B/alu_FS/alu_C0).
- alu_status  in  4  ALU {V, C, N, Z}.

## Operation

- States: IDLE, EXEC, MUL, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch op, a, b. Go to MUL if op=111, otherwise EXEC.
- Opcode to {FS, C0} mapping:
  - ADD: 01000, 0
  - SUB: 01010, 1
  - AND: 00000, 0
  - ORR: 00100, 0
  - EOR: 01100, 0
  - LSL: 10000, 0
  - LSR: 10100, 0
- EXEC (one cycle): drive alu_A=a, alu_B=b and the mapped FS/C0. Capture alu_F into resp_data. Go to DONE.
- Flags, EXEC ops:
  - ADD/SUB: resp_flags = alu_status.
  - Logic and shift ops: resp_flags = {0, 0, alu_status[1], alu_status[0]}.
- MUL:
  - Registers: acc=0, mcand=a, mplier=b, count=0.
  - Each cycle: drive alu_A=acc, alu_B=mcand, FS=01000, C0=0. If mplier[0]=1, acc<=alu_F, else acc unchanged. Then mcand<=mcand<<1, mplier<=mplier>>1 (local shifts), count<=count+1.
  - Exactly 64 iterations, no early exit. After iteration 64: resp_data=acc (low 64 bits of product, modulo 2^64) and resp_flags={0, 0, acc[63], acc==0}. Go to DONE.
- DONE: resp_valid=1; resp_data and resp_flags held stable. On resp_ready, go to IDLE.
- Outside EXEC/MUL: alu_A=0, alu_B=0, alu_FS=0, alu_C0=0.
- Reset in any state (including mid-MUL or in DONE with resp_ready low) aborts the operation: state IDLE, no response emitted, pending result discarded.

## Timing

- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_flags=0, all alu_* outputs 0.
- req_ready and alu_* are decoded combinationally from registered state and operands. resp_* are registered.
- Non-MUL: accept at edge t, EXEC in cycle t+1, resp_valid=1 from cycle t+2.
- MUL: accept at t, iterations in cycles t+1..t+64, resp_valid=1 from cycle t+65.
- resp handshake at edge u: IDLE in cycle u+1, so earliest next accept is edge u+1.
- Peak throughput: one non-MUL op per 3 cycles.
- req_ready=0 in EXEC, MUL and DONE; req_valid is ignored there.
- resp_valid stays 1 indefinitely until resp_ready.

## Test plan

- ADD 5+7 -> resp_data=12, flags 0000, resp_valid 2 cycles after accept. ADD 0x7FFF_FFFF_FFFF_FFFF+1 -> 0x8000_0000_0000_0000, V=1, N=1, C=0.
- SUB 5-5 -> 0, Z=1, C=1. SUB 3-5 -> 0xFFFF_FFFF_FFFF_FFFE, N=1, C=0, V=0.
- LSL 1 by b=63 -> 0x8000_0000_0000_0000, flags {0,0,1,0}. LSR 0xF0 by b=0x44 (shift 4) -> 0x0F. EOR 0xFF^0xFF -> 0, Z=1, C=V=0. Also check alu_FS/alu_C0 in EXEC for every opcode.
- MUL 0xFFFF_FFFF*0xFFFF_FFFF -> 0xFFFF_FFFE_0000_0001 with resp_valid exactly 65 cycles after accept. MUL 12345*0 -> 0, Z=1. MUL (2^63)*2 -> 0, Z=1 (wrap).
- Backpressure: resp_ready low 10 cycles -> resp_valid, resp_data and resp_flags stable, req_ready=0, new req_valid ignored. On release, next request accepted one cycle later.
- Reset during MUL iteration 30 -> next cycle req_ready=1, resp_valid=0, alu_* all 0. A following ADD 1+1 returns 2 normally.
